sd_sector_arbiter: RTL and testbench
====================================

Name: sd_sector_arbiter

Overview:
- Shares the single SD SPI sector reader between two requesters: the video fetch path (Vid) and the audio fetch path (Aud).
- Accepts whole-sector read requests and arbitrates them round-robin.
- Issues one start pulse and the latched 24-bit address to the reader, then routes the 512-byte stream back to the granted requester.
- Signals completion or timeout to that requester; sits between the AudVid peripheral fetch logic and the SD reader.

Parameters:
ADDR_W, 24, sector address width, matches the reader's address input
SECTOR_BYTES, 512, bytes per sector read
BCNT_W, 10, byte counter width; must satisfy 2^BCNT_W > SECTOR_BYTES
TIMEOUT_CYCLES, 1048575, max MasterCLK cycles without a byte before abort
TO_W, 20, timeout counter width

Ports:
MasterCLK  in  1  system clock; all logic on its rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
VidReq  in  1  video requests a sector; held high until VidDone
VidAddr  in  ADDR_W  video sector address; valid while VidReq high
AudReq  in  1  audio requests a sector; held high until AudDone
AudAddr  in  ADDR_W  audio sector address; valid while AudReq high
SdReady  in  1  reader initialised and idle, can accept a command
SdByteValid  in  1  one-cycle strobe: SdByte holds a new data byte
SdByte  in  8  data byte from reader
SdStart  out  1  one-cycle pulse: begin reading sector at SdAddr
SdAddr  out  ADDR_W  registered address of the current sector
OutByte  out  8  registered copy of the last accepted SdByte
VidGrant  out  1  video owns the reader (ISSUE through DONE)
AudGrant  out  1  audio owns the reader (ISSUE through DONE)
VidByteValid  out  1  OutByte valid for video, one cycle
AudByteValid  out  1  OutByte valid for audio, one cycle
VidDone  out  1  one-cycle pulse: video sector finished
AudDone  out  1  one-cycle pulse: audio sector finished
Timeout  out  1  sticky error flag; cleared on the next grant

Behaviour:
- Reset low (async): state=IDLE; every output 0 (SdAddr=0, OutByte=0); byte counter=0; timeout counter=0; last-served pointer=Aud, so Vid wins the first tie.
- IDLE:
  - Leave only when SdReady=1 and at least one Req is high.
  - Single requester: granted.
  - Both requesting: the one not last-served is granted.
  - On the grant edge: latch the chosen address into SdAddr, set the Grant, update last-served, clear Timeout, go to ISSUE.
- ISSUE: SdStart=1 for exactly this one cycle; byte counter=0; timeout counter=0; go to STREAM. Latency from Req sampled high in IDLE to SdStart high: 2 cycles.
- STREAM, on each SdByteValid=1:
  - OutByte<=SdByte.
  - The granted requester's ByteValid pulses on the next cycle.
  - Byte counter increments; timeout counter resets.
  - When the counter reaches SECTOR_BYTES, go to DONE; that 512th byte is still delivered.
- STREAM, no strobe: timeout counter increments. At TIMEOUT_CYCLES, set Timeout=1 and go to DONE with fewer bytes delivered.
- DONE: pulse the granted Done for 1 cycle, drop Grant, go to IDLE. A requester may re-request on the cycle after Done and is arbitrated normally.
- Ignored inputs:
  - SdByteValid outside STREAM: ignored, no ByteValid emitted.
  - Strobes beyond SECTOR_BYTES: ignored.
- Requester drops Req mid-transfer: the transfer still completes and bytes are still routed; the requester ignores them.
- A Req arriving while the other requester's transfer is in progress waits; it is served next, so neither requester starves.
- SdReady=0 while in IDLE: no grant. SdReady is not checked after ISSUE.
- Exclusivity: at most one Grant, one ByteValid, and one Done high in any cycle.
- Reset asserted mid-STREAM: immediate return to IDLE, no Done pulse, outputs 0.

Test Plan:
- Vid only, VidAddr=0x000123, 512 strobes with bytes 0x00..0xFF repeating → SdStart pulse 2 cycles after VidReq; SdAddr=0x000123; 512 VidByteValid pulses with matching OutByte; one VidDone; AudByteValid never high.
- VidReq and AudReq rise in the same cycle → Vid granted first; Aud starts on the next IDLE; a third back-to-back request from both → Aud served before Vid.
- Aud transfer in progress, VidReq rises at byte 100 → no second SdStart until AudDone; Vid then granted with its own address.
- STREAM with strobes stopping after 37 bytes and TIMEOUT_CYCLES=64 → Timeout=1, AudDone pulse, 37 AudByteValid total; Timeout clears on the next grant.
- Strobes while IDLE and a 513th strobe → no ByteValid for any of them; SdReady=0 with VidReq high → no SdStart until SdReady=1.
- Reset driven low at byte 200 → all outputs 0 asynchronously; after release, a pending VidReq restarts from ISSUE with byte counter 0.

Source files
------------

// File: rtl/sd_sector_arbiter.sv
// -----------------------------------------------------------------------------
// sd_sector_arbiter
//
// Shares one SD SPI sector reader between the video fetch path (Vid) and the
// audio fetch path (Aud). Whole-sector read requests are arbitrated
// round-robin. The winner's address is latched and a one-cycle start pulse
// goes to the reader. The byte stream is then routed back to the granted
// requester. Completion, or abort after a byte-starvation timeout, is
// signalled with a one-cycle Done pulse.
//
// Ports
//   MasterCLK     in   system clock, rising edge
//   Reset         in   asynchronous, active-low reset
//   VidReq        in   video sector request, held until VidDone
//   VidAddr       in   video sector address (valid while VidReq)
//   AudReq        in   audio sector request, held until AudDone
//   AudAddr       in   audio sector address (valid while AudReq)
//   SdReady       in   reader idle and able to accept a command
//   SdByteValid   in   one-cycle strobe, SdByte carries a new byte
//   SdByte        in   data byte from the reader
//   SdStart       out  one-cycle pulse: read the sector at SdAddr
//   SdAddr        out  latched address of the current sector
//   OutByte       out  registered copy of the last accepted SdByte
//   VidGrant      out  video owns the reader
//   AudGrant      out  audio owns the reader
//   VidByteValid  out  OutByte valid for video (one cycle)
//   AudByteValid  out  OutByte valid for audio (one cycle)
//   VidDone       out  one-cycle pulse: video sector finished
//   AudDone       out  one-cycle pulse: audio sector finished
//   Timeout       out  sticky starvation flag, cleared on the next grant
// -----------------------------------------------------------------------------
module sd_sector_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int SECTOR_BYTES   = 512,
  parameter int BCNT_W         = 10,
  parameter int TIMEOUT_CYCLES = 1048575,
  parameter int TO_W           = 20
) (
  input  logic              MasterCLK,
  input  logic              Reset,
  input  logic              VidReq,
  input  logic [ADDR_W-1:0] VidAddr,
  input  logic              AudReq,
  input  logic [ADDR_W-1:0] AudAddr,
  input  logic              SdReady,
  input  logic              SdByteValid,
  input  logic [7:0]        SdByte,
  output logic              SdStart,
  output logic [ADDR_W-1:0] SdAddr,
  output logic [7:0]        OutByte,
  output logic              VidGrant,
  output logic              AudGrant,
  output logic              VidByteValid,
  output logic              AudByteValid,
  output logic              VidDone,
  output logic              AudDone,
  output logic              Timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counter values at which the current strobe / idle cycle is the final one.
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(SECTOR_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   sd_addr_q,   sd_addr_d;
  logic [7:0]          out_byte_q,  out_byte_d;
  logic                sd_start_q,  sd_start_d;
  logic                vid_grant_q, vid_grant_d;
  logic                aud_grant_q, aud_grant_d;
  logic                vid_bv_q,    vid_bv_d;
  logic                aud_bv_q,    aud_bv_d;
  logic                vid_done_q,  vid_done_d;
  logic                aud_done_q,  aud_done_d;
  logic                timeout_q,   timeout_d;
  logic [BCNT_W-1:0]   bcnt_q,      bcnt_d;
  logic [TO_W-1:0]     tcnt_q,      tcnt_d;
  // 1 = audio was served last, so video wins the next tie.
  logic                last_aud_q,  last_aud_d;

  logic                pick_vid;

  always_comb begin
    state_d     = state_q;
    sd_addr_d   = sd_addr_q;
    out_byte_d  = out_byte_q;
    vid_grant_d = vid_grant_q;
    aud_grant_d = aud_grant_q;
    timeout_d   = timeout_q;
    bcnt_d      = bcnt_q;
    tcnt_d      = tcnt_q;
    last_aud_d  = last_aud_q;
    // Pulse outputs are high for a single cycle unless re-asserted below.
    sd_start_d  = 1'b0;
    vid_bv_d    = 1'b0;
    aud_bv_d    = 1'b0;
    vid_done_d  = 1'b0;
    aud_done_d  = 1'b0;
    // Round-robin: a lone requester wins; on a tie the one not served last.
    pick_vid    = VidReq && (!AudReq || last_aud_q);

    case (state_q)
      S_IDLE: begin
        if (SdReady && (VidReq || AudReq)) begin
          sd_addr_d   = pick_vid ? VidAddr : AudAddr;
          vid_grant_d = pick_vid;
          aud_grant_d = !pick_vid;
          last_aud_d  = !pick_vid;
          timeout_d   = 1'b0;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        sd_start_d = 1'b1;
        bcnt_d     = '0;
        tcnt_d     = '0;
        state_d    = S_STREAM;
      end

      S_STREAM: begin
        if (SdByteValid) begin
          out_byte_d = SdByte;
          vid_bv_d   = vid_grant_q;
          aud_bv_d   = aud_grant_q;
          bcnt_d     = bcnt_q + BCNT_W'(1);
          tcnt_d     = '0;
          // The last byte of the sector is delivered together with Done.
          if (bcnt_q == BCNT_LAST) begin
            vid_done_d = vid_grant_q;
            aud_done_d = aud_grant_q;
            state_d    = S_DONE;
          end
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
          if (tcnt_q == TO_LAST) begin
            timeout_d  = 1'b1;
            vid_done_d = vid_grant_q;
            aud_done_d = aud_grant_q;
            state_d    = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Strobes arriving here (e.g. beyond the sector end) are dropped.
        vid_grant_d = 1'b0;
        aud_grant_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      sd_addr_q   <= '0;
      out_byte_q  <= '0;
      sd_start_q  <= 1'b0;
      vid_grant_q <= 1'b0;
      aud_grant_q <= 1'b0;
      vid_bv_q    <= 1'b0;
      aud_bv_q    <= 1'b0;
      vid_done_q  <= 1'b0;
      aud_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
      bcnt_q      <= '0;
      tcnt_q      <= '0;
      last_aud_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sd_addr_q   <= sd_addr_d;
      out_byte_q  <= out_byte_d;
      sd_start_q  <= sd_start_d;
      vid_grant_q <= vid_grant_d;
      aud_grant_q <= aud_grant_d;
      vid_bv_q    <= vid_bv_d;
      aud_bv_q    <= aud_bv_d;
      vid_done_q  <= vid_done_d;
      aud_done_q  <= aud_done_d;
      timeout_q   <= timeout_d;
      bcnt_q      <= bcnt_d;
      tcnt_q      <= tcnt_d;
      last_aud_q  <= last_aud_d;
    end
  end

  assign SdStart      = sd_start_q;
  assign SdAddr       = sd_addr_q;
  assign OutByte      = out_byte_q;
  assign VidGrant     = vid_grant_q;
  assign AudGrant     = aud_grant_q;
  assign VidByteValid = vid_bv_q;
  assign AudByteValid = aud_bv_q;
  assign VidDone      = vid_done_q;
  assign AudDone      = aud_done_q;
  assign Timeout      = timeout_q;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sd_sector_arbiter
//
// Self-checking bench for sd_sector_arbiter. A transaction-level reference
// model predicts the round-robin winner, the expected address, the byte stream
// per requester and the timeout outcome; a monitor checks routed bytes and
// exclusivity every cycle.
// -----------------------------------------------------------------------------
module tb_sd_sector_arbiter;

  localparam int ADDR_W = 24;
  localparam int SECT   = 512;
  localparam int TO     = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              vid_req, aud_req, sd_ready, sd_bv;
  logic [ADDR_W-1:0] vid_addr, aud_addr;
  logic [7:0]        sd_byte;
  logic              SdStart, VidGrant, AudGrant, VidByteValid, AudByteValid;
  logic              VidDone, AudDone, Timeout;
  logic [ADDR_W-1:0] SdAddr;
  logic [7:0]        OutByte;

  always #5 clk = ~clk;

  sd_sector_arbiter #(
    .ADDR_W(ADDR_W), .SECTOR_BYTES(SECT), .BCNT_W(10),
    .TIMEOUT_CYCLES(TO), .TO_W(20)
  ) dut (
    .MasterCLK(clk), .Reset(rst_n),
    .VidReq(vid_req), .VidAddr(vid_addr),
    .AudReq(aud_req), .AudAddr(aud_addr),
    .SdReady(sd_ready), .SdByteValid(sd_bv), .SdByte(sd_byte),
    .SdStart(SdStart), .SdAddr(SdAddr), .OutByte(OutByte),
    .VidGrant(VidGrant), .AudGrant(AudGrant),
    .VidByteValid(VidByteValid), .AudByteValid(AudByteValid),
    .VidDone(VidDone), .AudDone(AudDone), .Timeout(Timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [7:0] q_byte[2][$];   // expected bytes per requester (0 = Vid, 1 = Aud)
  int         bv_cnt[2];
  int         done_cnt[2];
  int         start_cnt;
  bit         model_last_aud;  // which requester was served last

  function automatic bit model_pick_vid(input bit v, input bit a);
    return v && (!a || model_last_aud);
  endfunction

  // ---------------- monitor, samples 2 time units after the rising edge ----------------
  always begin
    @(posedge clk);
    #2;
    if (rst_n) begin
      check_eq("exclusive", 64'({VidGrant & AudGrant, VidByteValid & AudByteValid,
                                 VidDone & AudDone}), 64'd0);
      if (SdStart) start_cnt++;
      if (VidDone) done_cnt[0]++;
      if (AudDone) done_cnt[1]++;
      if (VidByteValid) begin
        bv_cnt[0]++;
        if (q_byte[0].size() == 0) check_eq("vid_unexpected_byte", 64'd1, 64'd0);
        else check_eq("vid_byte", 64'(OutByte), 64'(q_byte[0].pop_front()));
      end
      if (AudByteValid) begin
        bv_cnt[1]++;
        if (q_byte[1].size() == 0) check_eq("aud_unexpected_byte", 64'd1, 64'd0);
        else check_eq("aud_byte", 64'(OutByte), 64'(q_byte[1].pop_front()));
      end
    end
  end

  function automatic logic [63:0] all_outputs();
    return 64'({SdStart, SdAddr, OutByte, VidGrant, AudGrant, VidByteValid,
                AudByteValid, VidDone, AudDone, Timeout});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q_byte[0].delete();
    q_byte[1].delete();
    model_last_aud = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete sector transaction seen from the reader side.
  task automatic do_xfer(input bit exp_vid, input int nbytes, input bit seq_bytes,
                         input bit extra, input int raise_vid_at, input bit keep,
                         output int lat);
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        b;
    int                o, s0, b0;
    bit                found;
    o        = exp_vid ? 0 : 1;
    exp_addr = exp_vid ? vid_addr : aud_addr;
    lat      = -1;
    found    = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (SdStart) begin
        lat   = i;
        found = 1'b1;
        break;
      end
    end
    check_eq("start_seen", 64'(found), 64'd1);
    if (!found) return;
    check_eq("start_addr", 64'(SdAddr), 64'(exp_addr));
    check_eq("grant_vid", 64'(VidGrant), 64'(exp_vid));
    check_eq("grant_aud", 64'(AudGrant), 64'(!exp_vid));
    check_eq("timeout_cleared", 64'(Timeout), 64'd0);
    model_last_aud = !exp_vid;
    s0 = start_cnt;
    b0 = bv_cnt[o];
    for (int i = 0; i < nbytes; i++) begin
      if (i == raise_vid_at) vid_req = 1'b1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      b = seq_bytes ? 8'(i) : 8'($urandom);
      sd_byte = b;
      sd_bv   = 1'b1;
      q_byte[o].push_back(b);
      @(negedge clk);
      sd_bv = 1'b0;
    end
    if (extra) begin
      sd_byte = 8'($urandom);
      sd_bv   = 1'b1;
    end
    found = 1'b0;
    for (int j = 0; j < TO + 100; j++) begin
      if (VidDone || AudDone) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      sd_bv = 1'b0;
    end
    check_eq("done_seen", 64'(found), 64'd1);
    check_eq("done_vid", 64'(VidDone), 64'(exp_vid && found));
    check_eq("done_aud", 64'(AudDone), 64'(!exp_vid && found));
    check_eq("timeout_flag", 64'(Timeout), 64'(nbytes < SECT));
    check_eq("byte_count", 64'(bv_cnt[o] - b0), 64'(nbytes));
    check_eq("extra_start", 64'(start_cnt - s0), 64'd0);
    if (exp_vid) begin
      vid_req = keep;
      if (keep) vid_addr = ADDR_W'($urandom);
    end else begin
      aud_req = keep;
      if (keep) aud_addr = ADDR_W'($urandom);
    end
    if (extra) begin
      @(negedge clk);
      sd_bv = 1'b0;
    end
  endtask

  initial begin
    int lat, c0, d0, r, nb;
    bit ev, found;
    rst_n = 1'b0; vid_req = 1'b0; aud_req = 1'b0; sd_ready = 1'b1;
    sd_bv = 1'b0; sd_byte = '0; vid_addr = '0; aud_addr = '0;
    model_last_aud = 1'b1;
    bv_cnt[0] = 0; bv_cnt[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0; start_cnt = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_outputs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Video alone, counting byte pattern
    vid_addr = 24'h000123;
    vid_req  = 1'b1;
    ev = model_pick_vid(vid_req, aud_req);
    do_xfer(ev, SECT, 1'b1, 1'b0, -1, 1'b0, lat);
    check_eq("start_latency", 64'(lat), 64'd2);
    check_eq("aud_never_valid", 64'(bv_cnt[1]), 64'd0);
    check_eq("vid_done_once", 64'(done_cnt[0]), 64'd1);

    // Simultaneous requests after reset; video then re-requests
    do_reset();
    vid_addr = ADDR_W'($urandom);
    aud_addr = ADDR_W'($urandom);
    vid_req = 1'b1;
    aud_req = 1'b1;
    ev = model_pick_vid(vid_req, aud_req);
    do_xfer(ev, SECT, 1'b0, 1'b0, -1, 1'b1, lat);
    ev = model_pick_vid(vid_req, aud_req);
    do_xfer(ev, SECT, 1'b0, 1'b0, -1, 1'b0, lat);
    ev = model_pick_vid(vid_req, aud_req);
    do_xfer(ev, SECT, 1'b0, 1'b0, -1, 1'b0, lat);

    // Video arrives at byte 100 of an audio transfer
    aud_addr = ADDR_W'($urandom);
    vid_addr = ADDR_W'($urandom);
    aud_req  = 1'b1;
    ev = model_pick_vid(vid_req, aud_req);
    do_xfer(ev, SECT, 1'b0, 1'b0, 100, 1'b0, lat);
    ev = model_pick_vid(vid_req, aud_req);
    do_xfer(ev, SECT, 1'b0, 1'b0, -1, 1'b0, lat);

    // Strobes stop after 37 bytes
    aud_addr = ADDR_W'($urandom);
    aud_req  = 1'b1;
    ev = model_pick_vid(vid_req, aud_req);
    do_xfer(ev, 37, 1'b0, 1'b0, -1, 1'b0, lat);
    repeat (3) @(negedge clk);
    check_eq("timeout_sticky", 64'(Timeout), 64'd1);
    vid_addr = ADDR_W'($urandom);
    vid_req  = 1'b1;
    ev = model_pick_vid(vid_req, aud_req);
    do_xfer(ev, SECT, 1'b0, 1'b0, -1, 1'b0, lat);

    // Strobes while idle, then a 513th strobe
    c0 = bv_cnt[0] + bv_cnt[1];
    repeat (3) begin
      sd_byte = 8'($urandom);
      sd_bv   = 1'b1;
      @(negedge clk);
      sd_bv = 1'b0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check_eq("idle_strobes_ignored", 64'(bv_cnt[0] + bv_cnt[1] - c0), 64'd0);
    vid_addr = ADDR_W'($urandom);
    vid_req  = 1'b1;
    ev = model_pick_vid(vid_req, aud_req);
    c0 = bv_cnt[0] + bv_cnt[1];
    do_xfer(ev, SECT, 1'b0, 1'b1, -1, 1'b0, lat);
    repeat (3) @(negedge clk);
    check_eq("strobe_513_ignored", 64'(bv_cnt[0] + bv_cnt[1] - c0), 64'(SECT));

    // Reader not ready
    sd_ready = 1'b0;
    vid_addr = ADDR_W'($urandom);
    vid_req  = 1'b1;
    c0 = start_cnt;
    repeat (10) @(negedge clk);
    check_eq("no_start_unready", 64'(start_cnt - c0), 64'd0);
    check_eq("no_grant_unready", 64'(VidGrant), 64'd0);
    sd_ready = 1'b1;
    ev = model_pick_vid(vid_req, aud_req);
    do_xfer(ev, SECT, 1'b0, 1'b0, -1, 1'b0, lat);
    check_eq("ready_latency", 64'(lat), 64'd2);

    // Reset in the middle of a stream at byte 200
    vid_addr = ADDR_W'($urandom);
    vid_req  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (SdStart) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("mid_reset_start", 64'(found), 64'd1);
    model_last_aud = 1'b0;
    for (int i = 0; i < 200; i++) begin
      sd_byte = 8'($urandom);
      sd_bv   = 1'b1;
      q_byte[0].push_back(sd_byte);
      @(negedge clk);
      sd_bv = 1'b0;
    end
    @(negedge clk);
    d0 = done_cnt[0] + done_cnt[1];
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outputs", all_outputs(), 64'd0);
    q_byte[0].delete();
    q_byte[1].delete();
    model_last_aud = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ev = model_pick_vid(vid_req, aud_req);
    do_xfer(ev, SECT, 1'b0, 1'b0, -1, 1'b0, lat);
    check_eq("reset_no_extra_done", 64'(done_cnt[0] + done_cnt[1] - d0), 64'd1);
    check_eq("restart_latency", 64'(lat), 64'd2);

    // Randomized rounds
    for (int k = 0; k < 6; k++) begin
      if (!vid_req && !aud_req) begin
        r = $urandom_range(1, 3);
        if (r[0]) begin vid_addr = ADDR_W'($urandom); vid_req = 1'b1; end
        if (r[1]) begin aud_addr = ADDR_W'($urandom); aud_req = 1'b1; end
      end else if ($urandom_range(0, 1) == 1) begin
        if (!vid_req) begin vid_addr = ADDR_W'($urandom); vid_req = 1'b1; end
        else if (!aud_req) begin aud_addr = ADDR_W'($urandom); aud_req = 1'b1; end
      end
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 80)) : SECT;
      ev = model_pick_vid(vid_req, aud_req);
      do_xfer(ev, nb, 1'b0, 1'b0, -1, 1'($urandom_range(0, 1)), lat);
    end

    vid_req = 1'b0;
    aud_req = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("queues_drained", 64'(q_byte[0].size() + q_byte[1].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
